// File: rtl/interrupt_controller_if.sv
// CPU port-I/O bus between the pipeline's OUT/IN logic and a memory-mapped peripheral.
// Master drives address/data/strobe, slave returns combinational read data and hit.
interface interrupt_controller_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id,
    output out_port,
    output io_strb,
    input  rd_data,
    input  rd_hit
  );

  modport slave (
    input  port_id,
    input  out_port,
    input  io_strb,
    output rd_data,
    output rd_hit
  );
endinterface

// File: rtl/interrupt_controller.sv
// Synchronises, edge-detects and latches external interrupt sources, masks them and
// raises a one-cycle request to the pipeline at a safe point when interrupts are enabled.
module interrupt_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  MASK_PORT = 8'hE0,
  parameter logic [7:0]  PEND_PORT = 8'hE1,
  parameter logic [7:0]  ID_PORT   = 8'hE2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         irq_src,
  input  logic                       i_flag,
  input  logic                       pipe_busy,
  interrupt_controller_if.slave      bus,
  output logic                       cpu_int
);

  localparam int unsigned DW   = 8;
  localparam int unsigned IDXW = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    SERVICE  = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] s1;
  logic [NUM_SRC-1:0] s2;
  logic [NUM_SRC-1:0] h;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] active;
  logic               mask_wr;
  logic               req;
  logic               found;
  logic [IDXW-1:0]    idx;
  logic               unused_out_port;

  // Two-flop synchroniser plus history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      h  <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      h  <= s2;
    end
  end

  assign rise     = s2 & ~h;
  assign mask_wr  = bus.io_strb && (bus.port_id == MASK_PORT);
  assign pend_clr = (bus.io_strb && (bus.port_id == PEND_PORT)) ?
                    bus.out_port[NUM_SRC-1:0] : '0;
  assign unused_out_port = ^bus.out_port;

  // A new edge overrides a simultaneous write-1-to-clear on the same bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | rise;
      if (mask_wr) begin
        mask <= bus.out_port[NUM_SRC-1:0];
      end
    end
  end

  assign active = pend & mask;
  assign req    = |active;

  // Lowest-index eligible source wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        found = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_hit  = 1'b0;
    if (bus.port_id == MASK_PORT) begin
      bus.rd_data = DW'(mask);
      bus.rd_hit  = 1'b1;
    end else if (bus.port_id == PEND_PORT) begin
      bus.rd_data = DW'(pend);
      bus.rd_hit  = 1'b1;
    end else if (bus.port_id == ID_PORT) begin
      bus.rd_data = found ? {1'b0, 4'b0, idx} : 8'h80;
      bus.rd_hit  = 1'b1;
    end
  end

  // Request handshake: pulse, wait for the CPU to clear I, then wait for RETIE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cpu_int <= 1'b0;
    end else begin
      cpu_int <= 1'b0;
      case (state)
        IDLE: begin
          if (req && i_flag && !pipe_busy) begin
            state   <= REQ;
            cpu_int <= 1'b1;
          end
        end
        REQ:      state <= WAIT_ACK;
        WAIT_ACK: if (!i_flag) state <= SERVICE;
        SERVICE:  if (i_flag)  state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomised bench for interrupt_controller against a sample-history reference model.
module tb_interrupt_controller;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         i_flag = 1'b0;
  logic         pipe_busy = 1'b0;
  logic         cpu_int;

  interrupt_controller_if bus();

  interrupt_controller #(.NUM_SRC(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .i_flag   (i_flag),
    .pipe_busy(pipe_busy),
    .bus      (bus),
    .cpu_int  (cpu_int)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: source samples taken at the last three edges, pending, mask, handshake
  logic [N-1:0] smp1, smp2, smp3;
  logic [N-1:0] m_pend, m_mask;
  logic         m_int;
  bit           m_await_entry;
  bit           m_in_handler;
  bit           m_pulse_next;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_read(input logic [7:0] p);
    logic [N-1:0] act;
    act = m_pend & m_mask;
    if (p == 8'hE0) return {1'b1, 8'(m_mask)};
    if (p == 8'hE1) return {1'b1, 8'(m_pend)};
    if (p == 8'hE2) begin
      for (int i = 0; i < int'(N); i++)
        if (act[i]) return {1'b1, 8'(i)};
      return {1'b1, 8'h80};
    end
    return 9'h000;
  endfunction

  // Applies one rising edge of the reference behaviour using the inputs present at that edge
  task automatic model_edge();
    logic [N-1:0] clr;
    bit           eligible;
    if (!rst) begin
      {smp1, smp2, smp3} = '0;
      m_pend = '0; m_mask = '0; m_int = 1'b0;
      m_await_entry = 0; m_in_handler = 0; m_pulse_next = 0;
    end else begin
      eligible = (m_pend & m_mask) != '0;
      clr = (bus.io_strb && bus.port_id == 8'hE1) ? bus.out_port[N-1:0] : '0;
      m_int = 1'b0;
      if (m_pulse_next) begin
        m_pulse_next  = 0;
        m_await_entry = 1;
      end else if (m_await_entry) begin
        if (!i_flag) begin m_await_entry = 0; m_in_handler = 1; end
      end else if (m_in_handler) begin
        if (i_flag) m_in_handler = 0;
      end else if (eligible && i_flag && !pipe_busy) begin
        m_int = 1'b1;
        m_pulse_next = 1;
      end
      // a rise seen two samples ago becomes pending now
      m_pend = (m_pend & ~clr) | (smp2 & ~smp3);
      if (bus.io_strb && bus.port_id == 8'hE0) m_mask = bus.out_port[N-1:0];
      smp3 = smp2; smp2 = smp1; smp1 = irq_src;
    end
  endtask

  task automatic check_all();
    logic [7:0] saved;
    logic [7:0] ports [4];
    logic [8:0] e;
    saved = bus.port_id;
    chk("cpu_int", 8'(cpu_int), 8'(m_int));
    ports[0] = 8'hE0; ports[1] = 8'hE1; ports[2] = 8'hE2;
    ports[3] = 8'($urandom_range(0, 223));
    for (int k = 0; k < 4; k++) begin
      bus.port_id = ports[k];
      #1;
      e = exp_read(ports[k]);
      chk($sformatf("rd_data@%h", ports[k]), bus.rd_data, e[7:0]);
      chk($sformatf("rd_hit@%h", ports[k]), 8'(bus.rd_hit), 8'(e[8]));
    end
    bus.port_id = saved;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    bus.port_id = p; bus.out_port = d; bus.io_strb = 1'b1;
    tick();
    bus.io_strb = 1'b0;
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] d);
    logic [7:0] saved;
    saved = bus.port_id;
    bus.port_id = p;
    #1;
    d = bus.rd_data;
    bus.port_id = saved;
  endtask

  logic [7:0] r;
  int         pulses;

  initial begin
    bus.port_id = 8'h00; bus.out_port = 8'h00; bus.io_strb = 1'b0;

    // reset with all sources high
    rst = 1'b0; irq_src = 4'hF;
    ticks(2);
    chk("reset_cpu_int", 8'(cpu_int), 8'h00);
    rd(8'hE2, r); chk("reset_id", r, 8'h80);
    rd(8'hE0, r); chk("reset_mask", r, 8'h00);
    rd(8'hE1, r); chk("reset_pend", r, 8'h00);
    irq_src = 4'h0; rst = 1'b1;
    ticks(3);

    // basic request
    wr(8'hE0, 8'h01);
    i_flag = 1'b1;
    irq_src[0] = 1'b1;
    ticks(3);
    rd(8'hE1, r); chk("basic_pend", r, 8'h01);
    tick();
    chk("basic_pulse", 8'(cpu_int), 8'h01);
    tick();
    chk("basic_pulse_end", 8'(cpu_int), 8'h00);

    // handshake: vector entry, clear, RETIE
    i_flag = 1'b0;
    ticks(2);
    wr(8'hE1, 8'h01);
    rd(8'hE1, r); chk("w1c_pend", r, 8'h00);
    i_flag = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin tick(); pulses += int'(cpu_int); end
    chk("no_refire", 8'(pulses), 8'h00);
    irq_src = 4'h0;
    ticks(3);

    // deferral while pipeline busy
    wr(8'hE0, 8'h04);
    pipe_busy = 1'b1;
    irq_src[2] = 1'b1;
    ticks(3);
    rd(8'hE1, r); chk("defer_pend", r, 8'h04);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("defer_hold", 8'(cpu_int), 8'h00);
    end
    pipe_busy = 1'b0;
    tick();
    chk("defer_pulse", 8'(cpu_int), 8'h01);
    tick();
    chk("defer_single", 8'(cpu_int), 8'h00);
    i_flag = 1'b0; ticks(2);
    wr(8'hE1, 8'hFF);
    i_flag = 1'b1; irq_src = 4'h0;
    ticks(3);

    // priority and masking
    i_flag = 1'b0;
    wr(8'hE0, 8'h08);
    irq_src = 4'hA;
    ticks(4);
    rd(8'hE2, r); chk("prio_mask8", r, 8'h03);
    wr(8'hE0, 8'h0A);
    rd(8'hE2, r); chk("prio_maskA", r, 8'h01);
    wr(8'hE2, 8'h55);
    wr(8'h10, 8'hFF);
    rd(8'hE0, r); chk("ignored_writes", r, 8'h0A);
    wr(8'hE1, 8'hFF);
    irq_src = 4'h0;
    ticks(3);

    // edge and clear land on the same bit in the same cycle
    irq_src[2] = 1'b1;
    ticks(2);
    wr(8'hE1, 8'h04);
    rd(8'hE1, r); chk("race_set_wins", r & 8'h04, 8'h04);
    wr(8'hE1, 8'hFF);
    irq_src = 4'h0;
    ticks(3);

    // reset while waiting for vector entry
    wr(8'hE0, 8'h01);
    i_flag = 1'b1;
    irq_src[0] = 1'b1;
    ticks(5);
    irq_src = 4'h0;
    ticks(2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin tick(); pulses += int'(cpu_int); end
    chk("post_reset_quiet", 8'(pulses), 8'h00);

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ N'($urandom);
      if ($urandom_range(0, 4) == 0) i_flag = ~i_flag;
      pipe_busy = ($urandom_range(0, 3) == 0);
      bus.io_strb = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: bus.port_id = 8'hE0;
        1, 2: bus.port_id = 8'hE1;
        3: bus.port_id = 8'hE2;
        default: bus.port_id = 8'($urandom_range(0, 223));
      endcase
      bus.out_port = 8'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b0; else rst = 1'b1;
      tick();
    end
    bus.io_strb = 1'b0;
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Front end for the pipeline's `input_interrupt` line.
- Synchronises and edge-detects up to eight external interrupt sources, latches them as pending and applies a software mask.
- Issues a single-cycle interrupt request to the pipeline only when the CPU I flag is set and the pipeline control reports a safe point.
- Software controls it via OUT/IN on `port_id`/`out_port`/`io_strb`, and reads it back through the `in_port` mux.

Parameters:
- NUM_SRC, 4, number of interrupt sources; legal range 1..8.
- MASK_PORT, 8'hE0, port id of the mask register (read/write).
- PEND_PORT, 8'hE1, port id of the pending register (read; write-1-to-clear).
- ID_PORT, 8'hE2, port id of the highest-priority-source register (read only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-low (0 = reset), sampled on the clk rising edge.
- irq_src  in  NUM_SRC  asynchronous external interrupt lines; active on rising edge.
- i_flag  in  1  CPU interrupt-enable flag (I_FLAG output).
- pipe_busy  in  1  1 = pipeline cannot take an interrupt this cycle (branch/stall in flight).
- port_id  in  8  CPU port address.
- out_port  in  8  CPU OUT data.
- io_strb  in  1  one-cycle OUT write strobe.
- cpu_int  out  1  interrupt request to pipeline `input_interrupt`; one-cycle pulse.
- rd_data  out  8  read data for the `in_port` mux; combinational.
- rd_hit  out  1  1 when `port_id` matches MASK_PORT, PEND_PORT or ID_PORT; combinational.

Behaviour:
- Reset (rst=0 at an edge): sync flops, edge-history, pending, mask and FSM all go to 0/IDLE.
- Outputs during reset: cpu_int=0; rd_data/rd_hit follow `port_id` with zeroed state.
- Reset mid-request or mid-service aborts immediately; no request pulse follows reset.
- Synchronisation: per source, 2-flop synchroniser (s1, s2) plus a history flop h.
- Edge detect: edge = s2 & ~h.
- Pending: pend[i] is set on the edge following edge[i]=1.
- Latency: src high first sampled at edge k → s1 at k, s2 at k+1, pend at k+2.
- Pending clear: io_strb=1 with port_id=PEND_PORT clears every pend bit whose out_port bit is 1.
- Set wins if an edge and a clear hit the same bit in the same cycle.
- Mask write: io_strb=1 with port_id=MASK_PORT loads mask ← out_port[NUM_SRC-1:0]; bits above NUM_SRC are ignored.
- Unmask with pending: a masked source still latches pending; unmasking later makes it eligible.
- Request term: req = |(pend & mask).
- FSM IDLE → REQ when req & i_flag & ~pipe_busy.
- FSM REQ lasts exactly one cycle; cpu_int = (state==REQ); then → WAIT_ACK.
- FSM WAIT_ACK → SERVICE when i_flag==0 (CPU cleared I on vector entry).
- FSM SERVICE → IDLE when i_flag==1 (RETIE). A still-pending request may re-fire from IDLE no earlier than the following cycle.
- End-to-end: idle, enabled, not busy → cpu_int high during the cycle after edge k+3.
- Deferral: pipe_busy or i_flag=0 in IDLE holds the request; no pulses are lost or duplicated.
- Reads (combinational):
  - MASK_PORT → zero-extended mask.
  - PEND_PORT → zero-extended pend.
  - ID_PORT → {1'b0, 4'b0, idx} where idx is the lowest index i with pend[i]&mask[i]; returns 8'h80 when none.
  - Any other port → rd_data=0, rd_hit=0.
- Reads have no side effects.
- Writes to ID_PORT or to unmapped ports are ignored.
- An irq_src held high produces one pending set only; re-arm requires low then high.
- A pulse on irq_src must be ≥1 clk wide to be guaranteed captured.

Test Plan:
- Reset: hold rst=0 for 2 cycles with irq_src=4'hF → cpu_int=0; ID_PORT reads 8'h80; mask=0, pend=0.
- Basic request, no pipe_busy: mask=4'h1, i_flag=1, irq_src[0] rises before edge k → pend=4'h1 after edge k+2; cpu_int=1 for exactly one cycle after edge k+3.
- Handshake: drop i_flag → WAIT_ACK→SERVICE. W1C 8'h01 to PEND_PORT → pend=0. Raise i_flag → IDLE, no further cpu_int.
- Deferral: pend=4'h4 with mask=4'h4 while pipe_busy=1 for 5 cycles → no cpu_int; pipe_busy→0 → single pulse next cycle.
- Priority and masking: pend=4'hA with mask=4'h8 → ID_PORT reads 8'h03. Write mask=4'hA → ID_PORT reads 8'h01.
- Race: irq_src[2] edge lands the same cycle as a W1C of 8'h04 → pend[2] stays 1.
- Mid-service reset: rst=0 during WAIT_ACK → IDLE; cpu_int never pulses afterwards without a new edge.
